// File: rtl/harp_uart_pkg.sv
// Shared types and helpers for the Harp clock-sync UART transmitter.
// Holds the FSM state type, frame constants and configuration checks.
package harp_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;

  function automatic int cycles_per_bit(
    input int clk_hz,
    input int baud
  );
    return (baud > 0) ? (clk_hz / baud) : 0;
  endfunction

  // Legal only for an exact integer divider of at least 2 and 1 or 2 stop bits.
  function automatic bit cfg_ok(
    input int clk_hz,
    input int baud,
    input int stop
  );
    if (baud <= 0) return 1'b0;
    return (clk_hz % baud == 0) &&
           (clk_hz / baud >= 2) &&
           (stop == 1 || stop == 2);
  endfunction

endpackage

// File: rtl/harp_uart_baud.sv
// Bit-period tick generator for the Harp UART transmitter.
// tick marks the last cycle of each bit; clear realigns on an accepted start.
module harp_uart_baud
  import harp_uart_pkg::*;
#(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/harp_uart_tx.sv
// 8N1 UART transmitter fed by the Harp timestamp sequencer.
// Blanked frames keep identical timing but hold the line idle.
module harp_uart_tx
  import harp_uart_pkg::*;
#(
  parameter int CLK_RATE_HZ = 1000000,
  parameter int BAUD_RATE   = 100000,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] uart_data,
  input  logic       uart_start,
  input  logic       uart_blank,
  output logic       uart_end,
  output logic       tx,
  output logic       busy
);

  localparam int CPB = cycles_per_bit(CLK_RATE_HZ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS + STOP_BITS);

  if (!cfg_ok(CLK_RATE_HZ, BAUD_RATE, STOP_BITS)) begin : g_cfg_err
    $error("harp_uart_tx: bad clock/baud/stop configuration");
  end

  state_t     state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       blank_q, blank_d;
  logic       tx_q, tx_d;
  logic       tick;
  logic       accept;

  assign accept = (state_q == IDLE) && uart_start;

  harp_uart_baud #(
    .CYCLES(CPB)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_q   <= '0;
      shift_q <= '0;
      blank_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      bit_q   <= bit_d;
      shift_q <= shift_d;
      blank_q <= blank_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the next cycle, so tx stays a clean flop.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    blank_d = blank_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (uart_start) begin
          state_d = START;
          bit_d   = '0;
          shift_d = uart_data;
          blank_d = uart_blank;
          tx_d    = uart_blank;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 4'd1;
          tx_d    = blank_q | shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_DATA) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = blank_q | shift_q[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_q == LAST_IDX) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign uart_end = (state_q == STOP) && tick && (bit_q == LAST_IDX);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

endmodule
